// File: rtl/sim_mon_pkg.sv
// Shared constants for the simulation bus monitor: register window offsets,
// the END pass code and VCNT_CTRL bit positions.
package sim_mon_pkg;

  localparam logic [3:0]  OFF_CHAR      = 4'h0;
  localparam logic [3:0]  OFF_RSVD      = 4'h4;
  localparam logic [3:0]  OFF_END       = 4'h8;
  localparam logic [3:0]  OFF_VCNT_CTRL = 4'hC;

  localparam logic [31:0] PASS_CODE = 32'h0000_0000;

  localparam int unsigned EN  = 32'd0;
  localparam int unsigned CLR = 32'd1;

  // Word select as latched from haddr[3:2]
  typedef enum logic [1:0] {
    SEL_CHAR      = OFF_CHAR[3:2],
    SEL_RSVD      = OFF_RSVD[3:2],
    SEL_END       = OFF_END[3:2],
    SEL_VCNT_CTRL = OFF_VCNT_CTRL[3:2]
  } mon_sel_e;

endpackage

// File: rtl/sim_bus_monitor_ahb_wr_snoop.sv
// Passive AHB-Lite write snooper: remembers an accepted address phase inside
// the monitor window and strobes once when its data phase completes.
module ahb_wr_snoop
  import sim_mon_pkg::*;
#(
  parameter logic [31:0] MON_BASE = 32'h6000_FFF0
) (
  input  logic        i_ext_pad_clkmux_ehs_clk,
  input  logic        PI_SOC_RST_B,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        wr_stb,
  output logic [1:0]  wr_sel,
  output logic [31:0] wr_data
);

  logic       pend_q, pend_d;
  logic [1:0] sel_q, sel_d;
  logic       addr_hit_s;
  logic [2:0] unused_addr_s;

  assign unused_addr_s = {htrans[0], haddr[1:0]};

  // Address-phase capture; a stalled bus (hready=0) holds the pending phase
  always_comb begin
    addr_hit_s = htrans[1] & hwrite & hready & (haddr[31:4] == MON_BASE[31:4]);
    pend_d     = pend_q;
    sel_d      = sel_q;
    if (hready) begin
      pend_d = addr_hit_s;
      if (addr_hit_s) begin
        sel_d = haddr[3:2];
      end else begin
        sel_d = sel_q;
      end
    end else begin
      pend_d = pend_q;
      sel_d  = sel_q;
    end
  end

  // Pending-phase state
  always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
    if (PI_SOC_RST_B) begin
      pend_q <= 1'b0;
      sel_q  <= 2'd0;
    end else begin
      pend_q <= pend_d;
      sel_q  <= sel_d;
    end
  end

  assign wr_stb  = pend_q & hready;
  assign wr_sel  = sel_q;
  assign wr_data = hwdata;

endmodule

// File: rtl/sim_bus_monitor.sv
// Simulation monitor top: console character output, sticky pass/fail verdict,
// software virtual counter and a cycle-count watchdog. Observes the bus only.
module sim_bus_monitor
  import sim_mon_pkg::*;
#(
  parameter logic [31:0] MON_BASE   = 32'h6000_FFF0,
  parameter int unsigned MAX_CYCLES = 32'd30_000_000
) (
  input  logic        i_ext_pad_clkmux_ehs_clk,
  input  logic        PI_SOC_RST_B,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        char_vld,
  output logic [7:0]  char_data,
  output logic        sim_pass,
  output logic        sim_fail,
  output logic        sim_done,
  output logic        timeout,
  output logic [31:0] cycle_cnt,
  output logic [63:0] vcnt
);

  localparam logic [31:0] WDOG_LAST = 32'(MAX_CYCLES - 32'd1);

  logic        wr_stb_s;
  logic [1:0]  wr_sel_s;
  logic [31:0] wr_data_s;

  logic        char_vld_q, char_vld_d;
  logic [7:0]  char_data_q, char_data_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        en_q, en_d;
  logic [31:0] cycle_q, cycle_d;
  logic [63:0] vcnt_q, vcnt_d;
  logic        clr_s;
  logic        end_wr_s;

  ahb_wr_snoop #(.MON_BASE(MON_BASE)) u_snoop (
    .i_ext_pad_clkmux_ehs_clk (i_ext_pad_clkmux_ehs_clk),
    .PI_SOC_RST_B             (PI_SOC_RST_B),
    .htrans                   (htrans),
    .hwrite                   (hwrite),
    .haddr                    (haddr),
    .hwdata                   (hwdata),
    .hready                   (hready),
    .wr_stb                   (wr_stb_s),
    .wr_sel                   (wr_sel_s),
    .wr_data                  (wr_data_s)
  );

  // Register decode, first-wins verdict, watchdog and counters
  always_comb begin
    char_vld_d  = 1'b0;
    char_data_d = char_data_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    en_d        = en_q;
    clr_s       = 1'b0;
    end_wr_s    = 1'b0;
    cycle_d     = cycle_q + 32'd1;

    if (wr_stb_s) begin
      case (mon_sel_e'(wr_sel_s))
        SEL_CHAR: begin
          char_vld_d  = 1'b1;
          char_data_d = wr_data_s[7:0];
        end
        SEL_END: begin
          if (!done_q) begin
            end_wr_s = 1'b1;
            done_d   = 1'b1;
            if (wr_data_s == PASS_CODE) begin
              pass_d = 1'b1;
            end else begin
              fail_d = 1'b1;
            end
          end else begin
            end_wr_s = 1'b0;
          end
        end
        SEL_VCNT_CTRL: begin
          en_d  = wr_data_s[EN];
          clr_s = wr_data_s[CLR];
        end
        default: begin
          char_vld_d = 1'b0;
        end
      endcase
    end else begin
      char_vld_d = 1'b0;
    end

    // A same-edge END write owns the verdict, so the watchdog yields to it
    if (!done_q && !end_wr_s && (cycle_q == WDOG_LAST)) begin
      timeout_d = 1'b1;
      fail_d    = 1'b1;
      done_d    = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end

    if (clr_s) begin
      vcnt_d = 64'd0;
    end else if (en_q) begin
      vcnt_d = vcnt_q + 64'd1;
    end else begin
      vcnt_d = vcnt_q;
    end
  end

  // Output and state registers
  always_ff @(posedge i_ext_pad_clkmux_ehs_clk or posedge PI_SOC_RST_B) begin
    if (PI_SOC_RST_B) begin
      char_vld_q  <= 1'b0;
      char_data_q <= 8'd0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      en_q        <= 1'b0;
      cycle_q     <= 32'd0;
      vcnt_q      <= 64'd0;
    end else begin
      char_vld_q  <= char_vld_d;
      char_data_q <= char_data_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      en_q        <= en_d;
      cycle_q     <= cycle_d;
      vcnt_q      <= vcnt_d;
    end
  end

  assign char_vld  = char_vld_q;
  assign char_data = char_data_q;
  assign sim_pass  = pass_q;
  assign sim_fail  = fail_q;
  assign sim_done  = done_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_q;
  assign vcnt      = vcnt_q;

endmodule

// File: tb/tb_sim_bus_monitor.sv
// Directed bench for sim_bus_monitor with MAX_CYCLES shortened to 100.
module tb_sim_bus_monitor;

  localparam logic [31:0] BASE = 32'h6000_FFF0;

  logic        clk;
  logic        rst;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic        char_vld;
  logic [7:0]  char_data;
  logic        sim_pass;
  logic        sim_fail;
  logic        sim_done;
  logic        timeout;
  logic [31:0] cycle_cnt;
  logic [63:0] vcnt;

  int nvec;
  int nerr;

  sim_bus_monitor #(.MON_BASE(BASE), .MAX_CYCLES(32'd100)) dut (
    .i_ext_pad_clkmux_ehs_clk (clk),
    .PI_SOC_RST_B             (rst),
    .htrans                   (htrans),
    .hwrite                   (hwrite),
    .haddr                    (haddr),
    .hwdata                   (hwdata),
    .hready                   (hready),
    .char_vld                 (char_vld),
    .char_data                (char_data),
    .sim_pass                 (sim_pass),
    .sim_fail                 (sim_fail),
    .sim_done                 (sim_done),
    .timeout                  (timeout),
    .cycle_cnt                (cycle_cnt),
    .vcnt                     (vcnt)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  // Advance one clock and land just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'h0000_0000;
    hready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_bus();
    hwdata = 32'h0000_0000;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  // Address phase, ws wait states, then the completing data-phase edge
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, input int ws);
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr  = addr;
    hready = 1'b1;
    cyc();
    idle_bus();
    hwdata = data;
    hready = 1'b0;
    for (int i = 0; i < ws; i++) cyc();
    hready = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    if ({char_vld, char_data, sim_pass, sim_fail, sim_done, timeout} !== 12'h000) begin
      $display("FAIL reset_flags: got %h exp 000", {char_vld, char_data, sim_pass, sim_fail, sim_done, timeout});
      nerr++;
    end
    nvec++;
    if (cycle_cnt !== 32'd0 || vcnt !== 64'd0) begin
      $display("FAIL reset_cnt: got cyc=%0d vcnt=%0d exp 0/0", cycle_cnt, vcnt);
      nerr++;
    end
    nvec++;
    cyc();
    if (cycle_cnt !== 32'd1) begin
      $display("FAIL first_count: got %0d exp 1", cycle_cnt);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_char();
    do_reset();
    ahb_write(BASE + 32'h0, 32'hFFFF_FF41, 0);
    if (char_vld !== 1'b1 || char_data !== 8'h41) begin
      $display("FAIL char_pulse: got vld=%b data=%h exp 1/41", char_vld, char_data);
      nerr++;
    end
    nvec++;
    if ({sim_pass, sim_fail, sim_done, timeout} !== 4'b0000 || vcnt !== 64'd0) begin
      $display("FAIL char_side: got flags=%b vcnt=%0d exp 0000/0", {sim_pass, sim_fail, sim_done, timeout}, vcnt);
      nerr++;
    end
    nvec++;
    cyc();
    if (char_vld !== 1'b0 || char_data !== 8'h41) begin
      $display("FAIL char_one_cycle: got vld=%b data=%h exp 0/41", char_vld, char_data);
      nerr++;
    end
    nvec++;
    ahb_write(BASE + 32'h4, 32'h0000_0000, 0);
    if ({char_vld, sim_pass, sim_fail, sim_done} !== 4'b0000 || char_data !== 8'h41) begin
      $display("FAIL rsvd_ignored: got flags=%b data=%h exp 0000/41", {char_vld, sim_pass, sim_fail, sim_done}, char_data);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_end();
    do_reset();
    ahb_write(BASE + 32'h8, 32'h0000_0000, 2);
    if ({sim_pass, sim_fail, sim_done, timeout} !== 4'b1010) begin
      $display("FAIL end_pass: got p/f/d/t=%b exp 1010", {sim_pass, sim_fail, sim_done, timeout});
      nerr++;
    end
    nvec++;
    ahb_write(BASE + 32'h8, 32'h0000_0005, 0);
    if ({sim_pass, sim_fail, sim_done} !== 3'b101) begin
      $display("FAIL end_first_wins: got p/f/d=%b exp 101", {sim_pass, sim_fail, sim_done});
      nerr++;
    end
    nvec++;
    do_reset();
    ahb_write(BASE + 32'h8, 32'h0000_0100, 1);
    if ({sim_pass, sim_fail, sim_done, timeout} !== 4'b0110) begin
      $display("FAIL end_fail: got p/f/d/t=%b exp 0110", {sim_pass, sim_fail, sim_done, timeout});
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_vcnt();
    do_reset();
    ahb_write(BASE + 32'hC, 32'h0000_0001, 0);
    if (vcnt !== 64'd0) begin
      $display("FAIL vcnt_enable_edge: got %0d exp 0", vcnt);
      nerr++;
    end
    nvec++;
    repeat (8) cyc();
    ahb_write(BASE + 32'hC, 32'h0000_0000, 0);
    cyc();
    if (vcnt !== 64'd10) begin
      $display("FAIL vcnt_ten: got %0d exp 10", vcnt);
      nerr++;
    end
    nvec++;
    ahb_write(BASE + 32'hC, 32'h0000_0003, 0);
    if (vcnt !== 64'd0) begin
      $display("FAIL vcnt_clear: got %0d exp 0", vcnt);
      nerr++;
    end
    nvec++;
    cyc();
    cyc();
    if (vcnt !== 64'd2) begin
      $display("FAIL vcnt_resume: got %0d exp 2", vcnt);
      nerr++;
    end
    nvec++;
    ahb_write(BASE + 32'hC, 32'h0000_0002, 0);
    cyc();
    if (vcnt !== 64'd0) begin
      $display("FAIL vcnt_clear_only: got %0d exp 0", vcnt);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_watchdog();
    int budget;
    do_reset();
    budget = 0;
    while (cycle_cnt !== 32'd99 && budget < 200) begin
      cyc();
      budget++;
    end
    if (cycle_cnt !== 32'd99 || timeout !== 1'b0 || sim_done !== 1'b0) begin
      $display("FAIL wdog_pre: got cyc=%0d t=%b d=%b exp 99/0/0", cycle_cnt, timeout, sim_done);
      nerr++;
    end
    nvec++;
    cyc();
    if ({sim_pass, sim_fail, sim_done, timeout} !== 4'b0111 || cycle_cnt !== 32'd100) begin
      $display("FAIL wdog_fire: got p/f/d/t=%b cyc=%0d exp 0111/100", {sim_pass, sim_fail, sim_done, timeout}, cycle_cnt);
      nerr++;
    end
    nvec++;
    ahb_write(BASE + 32'h8, 32'h0000_0000, 0);
    if ({sim_pass, sim_fail, sim_done, timeout} !== 4'b0111) begin
      $display("FAIL wdog_sticky: got p/f/d/t=%b exp 0111", {sim_pass, sim_fail, sim_done, timeout});
      nerr++;
    end
    nvec++;
    // END data phase completes on the same edge the watchdog would fire
    do_reset();
    budget = 0;
    while (cycle_cnt !== 32'd98 && budget < 200) begin
      cyc();
      budget++;
    end
    ahb_write(BASE + 32'h8, 32'h0000_0000, 0);
    if ({sim_pass, sim_fail, sim_done, timeout} !== 4'b1010 || cycle_cnt !== 32'd100) begin
      $display("FAIL wdog_tie: got p/f/d/t=%b cyc=%0d exp 1010/100", {sim_pass, sim_fail, sim_done, timeout}, cycle_cnt);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_back_to_back();
    int pulses;
    do_reset();
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr  = BASE;
    cyc();
    hwdata = 32'h0000_0048;
    cyc();
    if (char_vld !== 1'b1 || char_data !== 8'h48) begin
      $display("FAIL b2b_first: got vld=%b data=%h exp 1/48", char_vld, char_data);
      nerr++;
    end
    nvec++;
    haddr  = 32'h6000_0000;
    hwdata = 32'h0000_0069;
    cyc();
    if (char_vld !== 1'b1 || char_data !== 8'h69) begin
      $display("FAIL b2b_second: got vld=%b data=%h exp 1/69", char_vld, char_data);
      nerr++;
    end
    nvec++;
    idle_bus();
    hwdata = 32'h0000_0077;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (char_vld === 1'b1) pulses++;
    end
    if (pulses != 0 || char_data !== 8'h69) begin
      $display("FAIL b2b_outside: got extra=%0d data=%h exp 0/69", pulses, char_data);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_reset_midop();
    int pulses;
    do_reset();
    ahb_write(BASE + 32'hC, 32'h0000_0001, 0);
    repeat (5) cyc();
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr  = BASE;
    cyc();
    idle_bus();
    hready = 1'b0;
    hwdata = 32'h0000_005A;
    #5;
    rst = 1'b1;
    #1;
    if ({char_vld, char_data, sim_pass, sim_fail, sim_done, timeout} !== 12'h000 ||
        cycle_cnt !== 32'd0 || vcnt !== 64'd0) begin
      $display("FAIL midop_async: got flags=%h cyc=%0d vcnt=%0d exp 000/0/0",
               {char_vld, char_data, sim_pass, sim_fail, sim_done, timeout}, cycle_cnt, vcnt);
      nerr++;
    end
    nvec++;
    cyc();
    cyc();
    rst    = 1'b0;
    hready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (char_vld === 1'b1) pulses++;
    end
    if (pulses != 0 || vcnt !== 64'd0 || cycle_cnt !== 32'd4) begin
      $display("FAIL midop_release: got pulses=%0d vcnt=%0d cyc=%0d exp 0/0/4", pulses, vcnt, cycle_cnt);
      nerr++;
    end
    nvec++;
  endtask

  initial begin
    nvec   = 0;
    nerr   = 0;
    rst    = 1'b1;
    hwdata = 32'h0000_0000;
    idle_bus();
    test_reset();
    test_char();
    test_end();
    test_vcnt();
    test_watchdog();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
